bcd_adder_display: RTL and testbench

- Parametrised successor to the single-digit BCD sum/display top level.
- Adds two DIGITS-wide packed-BCD operands serially, one digit per clock, with start/busy/done handshake, invalid-digit detection and registered result.
- Continuously time-multiplexes the registered sum onto a DIGITS-wide common-anode 7-segment display.
- The integrated scan prescaler replaces the separate clock divider; everything runs on the single system clock.

---
 rtl/bcd_adder_display.sv | 172 +++++++++++++++++
 tb/tb_bcd_adder_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_display.sv
// Serial packed-BCD adder with a multiplexed common-anode 7-segment scan of the registered sum.
// Latency: start sampled at edge 0 -> done (with sum/cout/err updated) in cycle DIGITS+1.
// Backpressure: start is only honoured in IDLE; requests while busy/done are dropped.
//
// Ports:
//   clk, rst         single system clock, synchronous active-high reset
//   start, a, b, cin one-cycle request with DIGITS-wide packed-BCD operands and decimal carry-in
//   busy, done       addition in progress / one-cycle result-update pulse
//   sum, cout, err   registered result, decimal carry-out, invalid-digit flag
//   An, Cout         active-low one-hot digit enables and {dp,g..a} segments
module bcd_adder_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic [DIGITS-1:0]     An,
  output logic [7:0]            Cout
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t state, state_nxt;

  // Working copies: operands shift right so the active digit is always [3:0];
  // the partial sum shifts right with each new digit entering at the top.
  logic [4*DIGITS-1:0] wa, wb, ws;
  logic                wc, werr;
  logic [IW-1:0]       idx;

  logic [4:0]          t;
  logic [3:0]          dig;
  logic                c_nxt, bad;
  logic [4*DIGITS-1:0] dig_top, ws_nxt;

  // ---------------------------------------------------------------- adder digit
  always_comb begin
    t       = {1'b0, wa[3:0]} + {1'b0, wb[3:0]} + {4'b0, wc};
    dig     = t[3:0];
    c_nxt   = 1'b0;
    if (t > 5'd9) begin
      // 4-bit wrap of t+6 is the decimal-corrected digit.
      dig   = t[3:0] + 4'd6;
      c_nxt = 1'b1;
    end
    bad     = (wa[3:0] > 4'd9) || (wb[3:0] > 4'd9);
    dig_top = '0;
    dig_top[4*DIGITS-1 -: 4] = dig;
    ws_nxt  = (ws >> 4) | dig_top;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

  // Results are written on the final ADD edge so they are already valid
  // during the DONE cycle, coincident with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa   <= '0;
      wb   <= '0;
      ws   <= '0;
      wc   <= 1'b0;
      werr <= 1'b0;
      idx  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wa   <= a;
            wb   <= b;
            wc   <= cin;
            werr <= 1'b0;
            ws   <= '0;
            idx  <= '0;
          end
        end
        ADD: begin
          wa   <= wa >> 4;
          wb   <= wb >> 4;
          wc   <= c_nxt;
          werr <= werr | bad;
          ws   <= ws_nxt;
          idx  <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
          if (idx == LAST_IDX) begin
            sum  <= ws_nxt;
            cout <= c_nxt;
            err  <= werr | bad;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- display scan
  logic [CW-1:0] cnt;
  logic [IW-1:0] sidx, sidx_nxt;
  logic [3:0]    sdig;
  logic [7:0]    seg_nxt;

  always_comb begin
    sidx_nxt = sidx;
    if (cnt == LAST_CNT)
      sidx_nxt = (sidx == LAST_IDX) ? '0 : sidx + IW'(1);
    sdig = 4'(sum >> {sidx_nxt, 2'b00});
    case (sdig)
      4'd0:    seg_nxt = 8'hC0;
      4'd1:    seg_nxt = 8'hF9;
      4'd2:    seg_nxt = 8'hA4;
      4'd3:    seg_nxt = 8'hB0;
      4'd4:    seg_nxt = 8'h99;
      4'd5:    seg_nxt = 8'h92;
      4'd6:    seg_nxt = 8'h82;
      4'd7:    seg_nxt = 8'hF8;
      4'd8:    seg_nxt = 8'h80;
      4'd9:    seg_nxt = 8'h90;
      default: seg_nxt = 8'hFF;
    endcase
    // Decimal point on the most significant digit shows the carry-out.
    if ((sidx_nxt == LAST_IDX) && cout)
      seg_nxt[7] = 1'b0;
  end

  // An and Cout are both computed from the upcoming index so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sidx <= '0;
      An   <= ~DIGITS'(1);
      Cout <= 8'hC0;
    end else begin
      cnt  <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      sidx <= sidx_nxt;
      An   <= ~(DIGITS'(1) << sidx_nxt);
      Cout <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_adder_display.sv
module tb_bcd_adder_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, err;
  logic [15:0] sum;
  logic [3:0]  An;
  logic [7:0]  Cout;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } res_t;

  res_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ndone = 0;

  bcd_adder_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
    .An(An), .Cout(Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) ndone <= ndone + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one addition, scrambles the inputs once it has started, optionally
  // re-pulses start in cycle 2, then pops the scoreboard entry when done rises.
  task automatic do_add(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                        input res_t expv, input bit repulse);
    int   cyc;
    res_t got;
    exp_q.push_back(expv);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    tick;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 12) begin
      check("busy_during_add", {31'b0, busy}, 32'd1);
      start = (repulse && cyc == 2) ? 1'b1 : 1'b0;
      tick;
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, DIGITS + 1);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    got = exp_q.pop_front();
    check("sum", {16'b0, sum}, {16'b0, got.sum});
    check("cout", {31'b0, cout}, {31'b0, got.cout});
    check("err", {31'b0, err}, {31'b0, got.err});
    tick;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (An !== target && n < 40) begin
      tick;
      n++;
    end
    check("an_reached", {31'b0, (An === target)}, 32'd1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset and free-running scan.
    repeat (3) tick;
    rst = 1'b0;
    check("rst_sum", {16'b0, sum}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_an", {28'b0, An}, 32'hE);
    check("rst_seg", {24'b0, Cout}, 32'hC0);
    for (int n = 1; n <= 16; n++) begin
      logic [3:0] ea;
      tick;
      ea = ~(4'b0001 << ((n / 4) % 4));
      check("scan_an", {28'b0, An}, {28'b0, ea});
      check("scan_seg", {24'b0, Cout}, 32'hC0);
    end

    // Carry ripples through three digits.
    do_add(16'h0999, 16'h0001, 1'b0, '{sum: 16'h1000, cout: 1'b0, err: 1'b0}, 1'b0);

    // Full overflow: dp lit on the top digit.
    do_add(16'h9999, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, err: 1'b0}, 1'b0);
    wait_an(4'h7);
    check("seg_dp_top", {24'b0, Cout}, 32'h40);
    wait_an(4'hE);
    check("seg_dp_low", {24'b0, Cout}, 32'hC0);

    // Carry-in plus an ignored second start.
    n0 = ndone;
    do_add(16'h1234, 16'h4321, 1'b1, '{sum: 16'h5556, cout: 1'b0, err: 1'b0}, 1'b1);
    repeat (8) tick;
    check("single_done", ndone - n0, 32'd1);
    check("sum_held", {16'b0, sum}, 32'h5556);
    check("busy_idle", {31'b0, busy}, 32'd0);

    // Invalid digit flagged; digit still corrected by the same rule.
    do_add(16'h00A0, 16'h0000, 1'b0, '{sum: 16'h0100, cout: 1'b0, err: 1'b1}, 1'b0);
    wait_an(4'hE); check("disp_d0", {24'b0, Cout}, 32'hC0);
    wait_an(4'hD); check("disp_d1", {24'b0, Cout}, 32'hC0);
    wait_an(4'hB); check("disp_d2", {24'b0, Cout}, 32'hF9);
    wait_an(4'h7); check("disp_d3", {24'b0, Cout}, 32'hC0);

    // Reset mid-operation aborts with no done pulse.
    tick;
    n0 = ndone;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_sum", {16'b0, sum}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_an", {28'b0, An}, 32'hE);
    check("abort_err", {31'b0, err}, 32'd0);
    repeat (8) tick;
    check("abort_no_done", ndone - n0, 32'd0);

    // Fresh addition after the abort.
    do_add(16'h5678, 16'h4444, 1'b0, '{sum: 16'h0122, cout: 1'b1, err: 1'b0}, 1'b0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
